// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Imported by the fetch interface, the PC register and the fetch unit top.
package rv_fetch_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP_DEFAULT  = 32'd4;
    localparam logic [XLEN-1:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return addr & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Bundle of the fetch unit's control, instruction-memory and IF/ID signals.
// master = fetch unit side, slave = surrounding pipeline / memory side.
interface if_fetch_unit_if;
    import rv_fetch_pkg::*;

    logic            stall;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic [XLEN-1:0] imem_rdata;
    logic            imem_ready;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            IF_ID_LE;
    logic            IF_ID_Flush;
    logic [XLEN-1:0] Instruction_OUT;
    logic [XLEN-1:0] PC_OUT;

    modport master (
        input  stall, redirect_valid, redirect_target, imem_rdata, imem_ready,
        output imem_req, imem_addr, IF_ID_LE, IF_ID_Flush, Instruction_OUT, PC_OUT
    );

    modport slave (
        output stall, redirect_valid, redirect_target, imem_rdata, imem_ready,
        input  imem_req, imem_addr, IF_ID_LE, IF_ID_Flush, Instruction_OUT, PC_OUT
    );

endinterface

// File: rtl/if_fetch_unit_pc_reg.sv
// Program counter register: redirect / increment / hold mux with a
// synchronous reset; the stored value is always word aligned.
module fetch_pc_reg
    import rv_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            inc,
    input  logic [XLEN-1:0] target,
    output logic [XLEN-1:0] pc
);

    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] pc_q;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = target;
        end else if (inc) begin
            pc_d = pc_q + PC_STEP;
        end
        pc_d = align_pc(pc_d);
    end

    // NOTE: state flops use non-blocking assignments; reset is synchronous here.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: drives the instruction-memory request and
// feeds the IF/ID register, absorbing wait states, stalls and redirects.
module if_fetch_unit
    import rv_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic           clk,
    input  logic           Reset,
    if_fetch_unit_if.master bus
);

    fetch_state_t    state_d, state_q;
    logic [XLEN-1:0] hold_d, hold_q;
    logic [XLEN-1:0] pc;
    logic            pc_load;
    logic            pc_inc;

    logic            imem_req;
    logic            if_id_le;
    logic            if_id_flush;
    logic [XLEN-1:0] instr_out;

    fetch_pc_reg #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_reg (
        .clk    (clk),
        .rst    (Reset),
        .load   (pc_load),
        .inc    (pc_inc),
        .target (bus.redirect_target),
        .pc     (pc)
    );

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        imem_req    = 1'b0;
        if_id_le    = 1'b0;
        if_id_flush = 1'b0;
        instr_out   = '0;
        pc_load     = 1'b0;
        pc_inc      = 1'b0;

        // Reset overrides whatever the registered state says this cycle.
        if (!Reset) begin
            unique case (state_q)
                IDLE: state_d = REQ;
                REQ: begin
                    imem_req = 1'b1;
                    if (bus.redirect_valid) begin
                        if_id_flush = 1'b1;
                        pc_load     = 1'b1;
                    end else if (bus.imem_ready) begin
                        if (bus.stall) begin
                            hold_d  = bus.imem_rdata;
                            state_d = HOLD;
                        end else begin
                            if_id_le  = 1'b1;
                            instr_out = bus.imem_rdata;
                            pc_inc    = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    instr_out = hold_q;
                    if (bus.redirect_valid) begin
                        if_id_flush = 1'b1;
                        pc_load     = 1'b1;
                        hold_d      = '0;
                        state_d     = REQ;
                    end else if (!bus.stall) begin
                        if_id_le = 1'b1;
                        pc_inc   = 1'b1;
                        state_d  = REQ;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    assign bus.imem_req        = imem_req;
    assign bus.imem_addr       = Reset ? RESET_PC : pc;
    assign bus.PC_OUT          = Reset ? RESET_PC : pc;
    assign bus.IF_ID_LE        = if_id_le;
    assign bus.IF_ID_Flush     = if_id_flush;
    assign bus.Instruction_OUT = instr_out;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: a directed vector table, corner-case
// sequences and random traffic, all compared against a behavioural model.
module tb_if_fetch_unit;
    import rv_fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] STEP   = 32'd4;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        rv;
        logic [31:0] rt;
        logic [31:0] rdata;
        logic        ready;
        logic        e_req;
        logic        e_le;
        logic        e_fl;
        logic [31:0] e_addr;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
    } vec_t;

    logic clk;
    logic Reset;
    if_fetch_unit_if bus ();

    if_fetch_unit #(
        .RESET_PC (RST_PC),
        .PC_STEP  (STEP)
    ) u_dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model: current PC, whether the first post-reset cycle has
    // passed, and a queue holding a word captured while stalled.
    bit          m_live = 1'b0;
    logic [31:0] m_pc   = RST_PC;
    logic [31:0] m_held[$];

    logic        s_le;
    logic [31:0] s_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t iv(input logic rst, input logic stall, input logic rv,
                                input logic [31:0] rt, input logic [31:0] rdata,
                                input logic ready);
        vec_t v;
        v.rst = rst; v.stall = stall; v.rv = rv; v.rt = rt; v.rdata = rdata; v.ready = ready;
        v.e_req = 1'b0; v.e_le = 1'b0; v.e_fl = 1'b0;
        v.e_addr = '0; v.e_instr = '0; v.e_pc = '0;
        return v;
    endfunction

    function automatic vec_t tv(input logic rst, input logic stall, input logic rv,
                                input logic [31:0] rt, input logic [31:0] rdata,
                                input logic ready, input logic e_req, input logic e_le,
                                input logic e_fl, input logic [31:0] e_addr,
                                input logic [31:0] e_instr, input logic [31:0] e_pc);
        vec_t v;
        v = iv(rst, stall, rv, rt, rdata, ready);
        v.e_req = e_req; v.e_le = e_le; v.e_fl = e_fl;
        v.e_addr = e_addr; v.e_instr = e_instr; v.e_pc = e_pc;
        return v;
    endfunction

    // Applies one cycle of inputs, checks outputs against the model (and the
    // table when asked), then advances the model and the clock.
    task automatic run_cycle(input vec_t v, input bit chk_tbl, input string tag);
        logic        e_req, e_le, e_fl;
        logic [31:0] e_addr, e_pc, e_instr, n_pc;
        bit          n_live, drop, push;

        Reset               = v.rst;
        bus.stall           = v.stall;
        bus.redirect_valid  = v.rv;
        bus.redirect_target = v.rt;
        bus.imem_rdata      = v.rdata;
        bus.imem_ready      = v.ready;
        #3;

        e_req = 1'b0; e_le = 1'b0; e_fl = 1'b0; e_instr = '0;
        e_addr = m_pc; e_pc = m_pc; n_pc = m_pc; n_live = m_live;
        drop = 1'b0; push = 1'b0;
        if (v.rst) begin
            e_addr = RST_PC; e_pc = RST_PC; n_pc = RST_PC; n_live = 1'b0; drop = 1'b1;
        end else if (!m_live) begin
            n_live = 1'b1;
        end else if (m_held.size() != 0) begin
            e_instr = m_held[0];
            if (v.rv) begin
                e_fl = 1'b1; n_pc = v.rt & ~32'h3; drop = 1'b1;
            end else if (!v.stall) begin
                e_le = 1'b1; n_pc = m_pc + STEP; drop = 1'b1;
            end
        end else begin
            e_req = 1'b1;
            if (v.rv) begin
                e_fl = 1'b1; n_pc = v.rt & ~32'h3;
            end else if (v.ready && !v.stall) begin
                e_le = 1'b1; e_instr = v.rdata; n_pc = m_pc + STEP;
            end else if (v.ready) begin
                push = 1'b1;
            end
        end

        check({tag, ".req"},   32'(bus.imem_req),    32'(e_req));
        check({tag, ".le"},    32'(bus.IF_ID_LE),    32'(e_le));
        check({tag, ".flush"}, 32'(bus.IF_ID_Flush), 32'(e_fl));
        check({tag, ".addr"},  bus.imem_addr,        e_addr);
        check({tag, ".instr"}, bus.Instruction_OUT,  e_instr);
        check({tag, ".pc"},    bus.PC_OUT,           e_pc);
        check({tag, ".le_and_flush"}, 32'(bus.IF_ID_LE & bus.IF_ID_Flush), 32'd0);
        if (chk_tbl) begin
            check({tag, ".tbl_req"},   32'(bus.imem_req),    32'(v.e_req));
            check({tag, ".tbl_le"},    32'(bus.IF_ID_LE),    32'(v.e_le));
            check({tag, ".tbl_flush"}, 32'(bus.IF_ID_Flush), 32'(v.e_fl));
            check({tag, ".tbl_addr"},  bus.imem_addr,        v.e_addr);
            check({tag, ".tbl_instr"}, bus.Instruction_OUT,  v.e_instr);
            check({tag, ".tbl_pc"},    bus.PC_OUT,           v.e_pc);
        end
        s_le = bus.IF_ID_LE;
        s_pc = bus.PC_OUT;

        m_pc   = n_pc;
        m_live = n_live;
        if (drop) m_held.delete();
        if (push) m_held.push_back(v.rdata);

        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] K = 32'hA5A5_0000;
    vec_t tbl[20];

    initial begin
        int le_cnt;

        Reset = 1'b1;
        bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_target = '0;
        bus.imem_rdata = '0; bus.imem_ready = 1'b0;
        @(posedge clk);
        #1;

        //          rst stall rv  target        rdata          rdy req le fl addr          instr          pc
        tbl[0]  = tv(1, 0, 0, 32'h0,         32'h0,         1, 0, 0, 0, 32'h0,        32'h0,         32'h0);
        tbl[1]  = tv(0, 0, 0, 32'h0,         K,             1, 0, 0, 0, 32'h0,        32'h0,         32'h0);
        tbl[2]  = tv(0, 0, 0, 32'h0,         K ^ 32'h0,     1, 1, 1, 0, 32'h0,        K ^ 32'h0,     32'h0);
        tbl[3]  = tv(0, 0, 0, 32'h0,         K ^ 32'h4,     1, 1, 1, 0, 32'h4,        K ^ 32'h4,     32'h4);
        tbl[4]  = tv(0, 1, 0, 32'h0,         K ^ 32'h8,     1, 1, 0, 0, 32'h8,        32'h0,         32'h8);
        tbl[5]  = tv(0, 1, 0, 32'h0,         32'h1234_5678, 1, 0, 0, 0, 32'h8,        K ^ 32'h8,     32'h8);
        tbl[6]  = tv(0, 1, 0, 32'h0,         32'h1234_5678, 1, 0, 0, 0, 32'h8,        K ^ 32'h8,     32'h8);
        tbl[7]  = tv(0, 0, 0, 32'h0,         32'h1234_5678, 1, 0, 1, 0, 32'h8,        K ^ 32'h8,     32'h8);
        tbl[8]  = tv(0, 0, 0, 32'h0,         K ^ 32'hC,     1, 1, 1, 0, 32'hC,        K ^ 32'hC,     32'hC);
        tbl[9]  = tv(0, 0, 1, 32'h103,       K ^ 32'h10,    1, 1, 0, 1, 32'h10,       32'h0,         32'h10);
        tbl[10] = tv(0, 0, 0, 32'h0,         K ^ 32'h100,   1, 1, 1, 0, 32'h100,      K ^ 32'h100,   32'h100);
        tbl[11] = tv(0, 0, 0, 32'h0,         32'hDEAD_BEEF, 0, 1, 0, 0, 32'h104,      32'h0,         32'h104);
        tbl[12] = tv(0, 1, 0, 32'h0,         32'hDEAD_BEEF, 0, 1, 0, 0, 32'h104,      32'h0,         32'h104);
        tbl[13] = tv(0, 0, 0, 32'h0,         K ^ 32'h104,   1, 1, 1, 0, 32'h104,      K ^ 32'h104,   32'h104);
        tbl[14] = tv(0, 1, 0, 32'h0,         K ^ 32'h108,   1, 1, 0, 0, 32'h108,      32'h0,         32'h108);
        tbl[15] = tv(0, 1, 1, 32'h200,       32'h0,         0, 0, 0, 1, 32'h108,      K ^ 32'h108,   32'h108);
        tbl[16] = tv(0, 0, 0, 32'h0,         K ^ 32'h200,   1, 1, 1, 0, 32'h200,      K ^ 32'h200,   32'h200);
        tbl[17] = tv(1, 0, 0, 32'h0,         32'h0,         0, 0, 0, 0, 32'h0,        32'h0,         32'h0);
        tbl[18] = tv(0, 0, 0, 32'h0,         32'h0,         1, 0, 0, 0, 32'h0,        32'h0,         32'h0);
        tbl[19] = tv(0, 0, 0, 32'h0,         32'h0,         0, 1, 0, 0, 32'h0,        32'h0,         32'h0);

        for (int i = 0; i < 20; i++) begin
            run_cycle(tbl[i], 1'b1, $sformatf("tbl%0d", i));
        end

        // Two wait states per word: address stable for three cycles, one LE per word.
        run_cycle(iv(1, 0, 0, 0, 0, 0), 1'b0, "ws_rst");
        run_cycle(iv(0, 0, 0, 0, 0, 0), 1'b0, "ws_idle");
        le_cnt = 0;
        for (int w = 0; w < 3; w++) begin
            for (int c = 0; c < 3; c++) begin
                check($sformatf("ws_addr_w%0d_c%0d", w, c), bus.imem_addr, RST_PC + 32'(4 * w));
                run_cycle(iv(0, 0, 0, 0, $urandom, c == 2), 1'b0, $sformatf("ws_w%0d_c%0d", w, c));
                if (s_le) le_cnt++;
            end
        end
        check("ws_le_count", 32'(le_cnt), 32'd3);
        check("ws_addr_after", bus.imem_addr, RST_PC + 32'd12);

        // Reset in the middle of a wait state and while holding a word.
        run_cycle(iv(0, 0, 0, 0, 0, 0), 1'b0, "rw_wait");
        run_cycle(iv(1, 0, 0, 0, 32'hCAFE_0001, 1), 1'b0, "rw_rst");
        check("rw_addr_after", bus.imem_addr, RST_PC);
        run_cycle(iv(0, 0, 0, 0, 0, 1), 1'b0, "rh_idle");
        run_cycle(iv(0, 1, 0, 0, 32'hCAFE_0002, 1), 1'b0, "rh_cap");
        run_cycle(iv(1, 0, 0, 0, 0, 1), 1'b0, "rh_rst");
        run_cycle(iv(0, 0, 0, 0, 0, 1), 1'b0, "rh_idle2");
        check("rh_addr_after", bus.imem_addr, RST_PC);

        // Redirect during IDLE is ignored.
        run_cycle(iv(1, 0, 0, 0, 0, 0), 1'b0, "ri_rst");
        run_cycle(iv(0, 0, 1, 32'h300, 0, 1), 1'b0, "ri_idle");
        check("ri_addr_after", bus.imem_addr, RST_PC);

        // PC wrap: the top word is fetched, then the address wraps to zero.
        run_cycle(iv(0, 0, 1, 32'hFFFF_FFFF, 0, 0), 1'b0, "wr_redir");
        check("wr_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
        run_cycle(iv(0, 0, 0, 0, 32'h0BAD_F00D, 1), 1'b0, "wr_fetch");
        check("wr_le", 32'(s_le), 32'd1);
        check("wr_pc_out", s_pc, 32'hFFFF_FFFC);
        check("wr_addr_wrapped", bus.imem_addr, 32'h0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            run_cycle(iv(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
                         ($urandom_range(0, 7) == 0), $urandom, $urandom,
                         ($urandom_range(0, 1) == 1)),
                      1'b0, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

- Instruction-fetch front end of the RISC-V pipeline.
- Holds the PC and drives the instruction-memory request.
- Produces the load-enable, flush, instruction word and PC consumed by the IF/ID pipeline register; it is the producer side of that register's interface.
- Absorbs memory wait states, hazard-unit stalls and control-transfer redirects from EX.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 0.
- PC_STEP, 4: sequential PC increment in bytes.

- clk  in  1: single clock, rising edge.
- Reset  in  1: synchronous, active-high reset.
- stall  in  1: hazard-unit stall; do not load IF/ID this cycle.
- redirect_valid  in  1: taken branch/JAL/JALR from EX this cycle.
- redirect_target  in  32: new PC; bits [1:0] ignored, treated as 00.
- imem_rdata  in  32: instruction word, valid when imem_ready=1.
- imem_ready  in  1: memory completes the current request this cycle (same-cycle response allowed).
- imem_req  out  1: fetch request.
- imem_addr  out  32: fetch address, equal to the PC register.
- IF_ID_LE  out  1: load enable to IF/ID.
- IF_ID_Flush  out  1: drives the IF/ID Reset input (clears it to 0).
- Instruction_OUT  out  32: instruction word to IF/ID.
- PC_OUT  out  32: PC of Instruction_OUT.

## Operation
- States:
  - IDLE: first cycle after reset.
  - REQ: request outstanding.
  - HOLD: word captured during stall.
- Priority per cycle: Reset > redirect_valid > stall > imem_ready.
- Reset: PC<=RESET_PC, state<=IDLE, hold buffer<=0.
- IDLE: imem_req=0, all strobes 0; next state REQ.
- REQ:
  - imem_req=1, imem_addr=PC.
  - ready=1, stall=0: IF_ID_LE=1, Instruction_OUT=imem_rdata, PC_OUT=PC, PC<=PC+PC_STEP; stay in REQ.
  - ready=1, stall=1: hold buffer<=imem_rdata; go to HOLD; LE=0; PC unchanged.
  - ready=0: stay in REQ, address held stable, LE=0. stall is irrelevant here.
- HOLD:
  - imem_req=0; Instruction_OUT=hold buffer.
  - stall=1: stay in HOLD.
  - stall=0: IF_ID_LE=1, PC<=PC+PC_STEP, go to REQ.
- redirect_valid=1 in any state except IDLE:
  - PC<={redirect_target[31:2],2'b00}; go to REQ.
  - IF_ID_Flush=1, IF_ID_LE=0.
  - Any imem_rdata returned in the same cycle is discarded; hold buffer contents are discarded.
- redirect_valid in IDLE: ignored.
- PC arithmetic: 32-bit, modulo 2^32; 32'hFFFF_FFFC+4 wraps to 32'h0.
- IF_ID_LE and IF_ID_Flush are never both 1.

## Timing
- All outputs are combinational from state, PC and inputs. IF/ID captures on the same rising edge.
- Reset values (cycle with Reset=1 and the following IDLE cycle):
  - imem_req=0, IF_ID_LE=0, IF_ID_Flush=0.
  - Instruction_OUT=0, PC_OUT=RESET_PC, imem_addr=RESET_PC.
- Instruction_OUT=0 whenever IF_ID_LE=0 and state!=HOLD.
- First request is issued 1 cycle after Reset deasserts.
- Zero-wait memory sustains one IF_ID_LE per cycle.
- N wait states add N cycles per instruction.
- Redirect-to-first-LE latency: 1 cycle with zero-wait memory.
- Reset asserted mid-request or in HOLD: request is dropped, the held word is lost, no LE that cycle.

## Structure
- Package rv_fetch_pkg:
  - fetch_state_t enum {IDLE, REQ, HOLD}.
  - RESET_PC_DEFAULT, PC_STEP_DEFAULT.
  - XLEN=32.
- Sub-module fetch_pc_reg: 32-bit PC register.
  - Synchronous reset to RESET_PC.
  - Next-PC mux: redirect / increment / hold.
  - Forces bits [1:0]=0.
- The FSM and hold buffer live in if_fetch_unit.

## Test plan
- Reset, then imem_ready=1 constantly with rdata=PC^32'hA5A5_0000 -> IF_ID_LE first high 1 cycle after reset; PC_OUT sequence 0,4,8,12 on consecutive cycles.
- Memory with 2 wait states -> imem_addr stable for 3 cycles per word; IF_ID_LE every 3rd cycle; PC advances by 4 only on LE.
- stall=1 for 3 cycles arriving with ready=1 at PC=8 -> HOLD; imem_req=0; when stall drops, LE=1 with the captured word and PC_OUT=8; next fetch at 12 with no refetch of 8.
- redirect_valid=1, target=32'h0000_0103, ready=1 in the same cycle -> IF_ID_Flush=1, LE=0, word discarded; next cycle imem_addr=32'h0000_0100.
- Redirect and stall together while in HOLD -> flush wins; hold buffer dropped; next cycle REQ at the target.
- Reset=1 mid-wait-state, and PC at 32'hFFFF_FFFC with ready=1 -> outputs return to reset values next cycle; after the wrap case, imem_addr=0.
